// File: rtl/music_pkg.sv
// music_pkg: shared constants, FSM state type and silence helper for the music player.
package music_pkg;
  localparam int unsigned BEAT_TICKS_DEF = 12_500_000;
  localparam int unsigned SONG_LEN_DEF = 384;
  localparam logic [31:0] REST_CODE = 32'd2500;
  // Tone periods in clk cycles at 50 MHz
  localparam logic [31:0] NOTE_C4 = 32'd191113;
  localparam logic [31:0] NOTE_D4 = 32'd170262;
  localparam logic [31:0] NOTE_E4 = 32'd151686;
  localparam logic [31:0] NOTE_F4 = 32'd143173;
  localparam logic [31:0] NOTE_G4 = 32'd127551;
  localparam logic [31:0] NOTE_A4 = 32'd113636;
  localparam logic [31:0] NOTE_B4 = 32'd101239;
  localparam logic [31:0] NOTE_C5 = 32'd95556;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_PLAY, S_DONE} state_t;
  function automatic logic is_silent(input logic [31:0] note, input logic [31:0] rest);
    return note == rest || note < 32'd2;
  endfunction
endpackage

// File: rtl/tone_gen.sv
// tone_gen: per-entry square-wave generator; restart latches the note and resets the phase.
module tone_gen
  import music_pkg::*;
#(
  parameter logic [31:0] REST_CODE = music_pkg::REST_CODE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_restart,
  input  logic        i_run,
  input  logic [31:0] i_note,
  output logic        o_buzzer
);
  logic [31:0] r_note, r_cnt, w_cnt_nxt;
  logic        w_silent;
  always_comb begin
    w_cnt_nxt = (r_cnt == r_note - 32'd1) ? '0 : r_cnt + 32'd1;
    w_silent = is_silent(r_note, REST_CODE);
  end
  // Buzzer is registered from the next count so it lines up with the counter each cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_note <= '0;
      r_cnt <= '0;
      o_buzzer <= 1'b0;
    end else if (i_restart) begin
      r_note <= i_note;
      r_cnt <= '0;
      o_buzzer <= !is_silent(i_note, REST_CODE);
    end else if (i_run) begin
      r_cnt <= w_cnt_nxt;
      o_buzzer <= !w_silent && (w_cnt_nxt < (r_note >> 1));
    end else
      o_buzzer <= 1'b0;
endmodule

// File: rtl/music_player.sv
// music_player: steps through a song ROM, playing each entry for one beat on the buzzer.
module music_player
  import music_pkg::*;
#(
  parameter int unsigned BEAT_TICKS = BEAT_TICKS_DEF,
  parameter int unsigned SONG_LEN = SONG_LEN_DEF,
  parameter logic [31:0] REST_CODE = music_pkg::REST_CODE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  output logic [8:0]  rom_addr,
  input  logic [31:0] rom_note,
  output logic        buzzer,
  output logic        busy,
  output logic        done
);
  state_t      r_state, w_next;
  logic [23:0] r_beat;
  logic [8:0]  w_addr_nxt;
  logic        w_beat_last, w_last_addr, w_restart, w_run;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_beat_last = r_beat == 24'(BEAT_TICKS - 1);
    w_last_addr = rom_addr == 9'(SONG_LEN - 1);
    w_next = r_state == S_IDLE ? ((start && !stop) ? S_ADDR : S_IDLE) :
             stop ? S_IDLE :
             r_state == S_ADDR ? S_WAIT :
             r_state == S_WAIT ? S_PLAY :
             r_state == S_PLAY ? (!w_beat_last ? S_PLAY :
                                  (!w_last_addr || loop_en) ? S_ADDR : S_DONE) :
             S_IDLE;
  end
  always_comb begin
    w_restart = r_state == S_WAIT && w_next == S_PLAY;
    w_run = r_state == S_PLAY && w_next == S_PLAY;
    w_addr_nxt = (r_state == S_IDLE && w_next == S_ADDR) ? '0 :
                 (r_state == S_PLAY && w_next == S_ADDR) ? (w_last_addr ? '0 : rom_addr + 9'd1) :
                 rom_addr;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rom_addr <= '0;
      r_beat <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      rom_addr <= w_addr_nxt;
      r_beat <= w_run ? r_beat + 24'd1 : '0;
      busy <= w_next != S_IDLE;
      done <= w_next == S_DONE;
    end
  tone_gen #(.REST_CODE(REST_CODE)) u_tone (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_restart(w_restart),
    .i_run    (w_run),
    .i_note   (rom_note),
    .o_buzzer (buzzer)
  );
endmodule

// File: doc/music_player.md
MUSIC_PLAYER -- requirements
Module: music_player

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- BEAT_TICKS, 12_500_000: clk cycles of PLAY per song entry (0.25 s at 50 MHz).
- SONG_LEN, 384: number of song entries, addresses 0..SONG_LEN-1.
- REST_CODE, 2500: note word meaning silence.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: begin playback from address 0.
- stop, in, 1: abort playback.
- loop_en, in, 1: wrap to address 0 after the last entry instead of finishing.
- rom_addr, out, 9: song ROM address.
- rom_note, in, 32: tone period in clk cycles, valid one clk edge after rom_addr is sampled.
- buzzer, out, 1: square-wave tone output.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse at natural song end.

Function
REQ-003 The FSM SHALL have states IDLE, ADDR, WAIT, PLAY and DONE, all outputs registered.
REQ-004 In IDLE, start=1 and stop=0 SHALL set rom_addr to 0 and enter ADDR.
REQ-005 ADDR SHALL go to WAIT after one cycle, and WAIT SHALL go to PLAY after one cycle.
REQ-006 On entering PLAY, rom_note SHALL be latched into note_r, and the beat and tone counters SHALL clear.
REQ-007 PLAY SHALL last exactly BEAT_TICKS cycles, so each entry occupies BEAT_TICKS+2 cycles.
REQ-008 At the end of PLAY with rom_addr < SONG_LEN-1, rom_addr SHALL increment and the FSM SHALL enter ADDR.
REQ-009 At the end of PLAY with rom_addr = SONG_LEN-1:
- loop_en=1: rom_addr SHALL go to 0 and the FSM SHALL enter ADDR.
- loop_en=0: the FSM SHALL enter DONE.
REQ-010 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-011 In PLAY, the tone counter SHALL count 0..note_r-1 and wrap; buzzer SHALL be 1 while count < note_r>>1, else 0.
REQ-012 If note_r = REST_CODE, note_r = 0 or note_r = 1, buzzer SHALL stay 0 for the whole entry.
REQ-013 buzzer SHALL be 0 in IDLE, ADDR, WAIT and DONE; tone phase restarts at every entry, including repeated notes.
REQ-014 stop=1 in any non-IDLE state SHALL force IDLE on the next edge with buzzer=0 and done=0.
REQ-015 stop has priority over start when both are high.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 The beat counter SHALL be 24 bits wide and the tone counter 32 bits wide; the BEAT_TICKS-1 compare SHALL be unsigned.

Reset
REQ-018 While rst_n=0, state SHALL be IDLE and rom_addr, note_r, both counters, buzzer, busy and done SHALL all be 0.
REQ-019 Reset mid-playback SHALL abandon the song; the next start SHALL begin again at address 0.

Structure
REQ-020 Package music_pkg SHALL hold the note-period constants, REST_CODE, the default SONG_LEN, the default BEAT_TICKS and the FSM state enum.
REQ-021 Tone generation (note_r, tone counter, buzzer, silence detect) SHALL be a sub-module tone_gen with a restart input pulsed on PLAY entry.

Verification
REQ-022 Every scenario SHALL use BEAT_TICKS=8, SONG_LEN=4 and a 1-cycle registered ROM model holding [4, 2500, 6, 4].
REQ-023 The bench SHALL cover these directed scenarios:
- Basic play: start pulse -> rom_addr 0,1,2,3 with 10 cycles per entry; done pulses exactly once about 41 cycles after start; busy falls the following cycle.
- Tone shape: entry 0 (note 4) -> buzzer 1,1,0,0,1,1,0,0; entry 1 (2500) -> buzzer 0 for all 8 PLAY cycles; entry 2 (note 6) -> buzzer 1,1,1,0,0,0,1,1.
- Loop: loop_en=1 -> after address 3, rom_addr returns to 0, done never pulses, busy stays 1.
- Abort: stop during entry 2 PLAY -> next cycle IDLE, buzzer=0, busy=0, no done; a later start restarts at address 0.
- Collisions: start and stop high together in IDLE -> stays IDLE; start during PLAY -> rom_addr sequence unchanged.
- Async reset: rst_n low mid-entry 1 -> all outputs 0 immediately, without waiting for a clock edge; after release, start -> address 0.
